m_phy_lane_s2p: RTL and testbench

Lane-side serial-to-parallel converter for the M-PHY receive path; the receive-side counterpart of the lane parallel-to-serial shifter. It accepts one line bit per enabled clock, MSB (bit 9) first, and hunts for the 8b10b K28.5 comma to find symbol boundaries. Once locked, it emits one 10-bit symbol per ten accepted bits. Output feeds the lane 8b10b decoder.

---
 rtl/m_phy_lane_s2p.sv | 127 ++++++++++++
 tb/tb_m_phy_lane_s2p.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/m_phy_lane_s2p.sv
// m_phy_lane_s2p: receive-side serial-to-parallel converter for one M-PHY lane.
// It takes one line bit per enabled clock, MSB (bit 9) first, and hunts for a
// K28.5 comma to find the symbol boundary. Once locked, it emits one 10-bit
// symbol every ten accepted bits. Repeated commas that land off the locked
// boundary force a return to the hunt.
//
// Ports:
//   clk           receive bit clock, rising edge
//   reset         asynchronous active-low reset
//   enable        qualifies serial_in; one bit is accepted per enabled clock
//   serial_in     received line bit
//   align_en      permits comma acquisition while hunting
//   parallel_out  recovered symbol; bit 9 is the first bit received
//   valid         one-cycle pulse; parallel_out was updated this cycle
//   comma_det     qualifies valid; the emitted symbol is a comma
//   aligned       high while locked

module m_phy_lane_s2p #(
    parameter logic [9:0]  COMMA_NEG      = 10'h0FA,
    parameter logic [9:0]  COMMA_POS      = 10'h305,
    parameter int unsigned MISALIGN_LIMIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       serial_in,
    input  logic       align_en,
    output logic [9:0] parallel_out,
    output logic       valid,
    output logic       comma_det,
    output logic       aligned
);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e     state_q, state_d;
    logic [8:0] sh_q, sh_d;          // only nine history bits are needed
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] misalign_q, misalign_d;
    logic [9:0] par_q, par_d;
    logic       valid_q, valid_d;
    logic       comma_q, comma_d;

    logic [9:0] window;
    logic       is_comma;
    logic [3:0] misalign_inc;

    assign window       = {sh_q, serial_in};
    assign is_comma     = (window == COMMA_NEG) || (window == COMMA_POS);
    assign misalign_inc = misalign_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        misalign_d = misalign_q;
        par_d      = par_q;
        valid_d    = 1'b0;
        comma_d    = 1'b0;

        if (enable) begin
            sh_d = window[8:0];
            unique case (state_q)
                StHunt: begin
                    if (align_en && is_comma) begin
                        par_d      = window;
                        valid_d    = 1'b1;
                        comma_d    = 1'b1;
                        bit_cnt_d  = 4'd0;
                        misalign_d = 4'd0;
                        state_d    = StLocked;
                    end
                end
                StLocked: begin
                    if (bit_cnt_q == 4'd9) begin
                        par_d     = window;
                        valid_d   = 1'b1;
                        comma_d   = is_comma;
                        bit_cnt_d = 4'd0;
                        if (is_comma) begin
                            misalign_d = 4'd0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (is_comma) begin
                            // Comma away from the boundary: count toward relock.
                            if (misalign_inc == 4'(MISALIGN_LIMIT)) begin
                                state_d    = StHunt;
                                misalign_d = 4'd0;
                                bit_cnt_d  = 4'd0;
                            end else begin
                                misalign_d = misalign_inc;
                            end
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StHunt;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            misalign_q <= '0;
            par_q      <= '0;
            valid_q    <= 1'b0;
            comma_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bit_cnt_q  <= bit_cnt_d;
            misalign_q <= misalign_d;
            par_q      <= par_d;
            valid_q    <= valid_d;
            comma_q    <= comma_d;
        end
    end

    assign parallel_out = par_q;
    assign valid        = valid_q;
    assign comma_det    = comma_q;
    assign aligned      = (state_q == StLocked);

endmodule

// File: tb/tb_m_phy_lane_s2p.sv
// Directed bench for m_phy_lane_s2p: acquisition, locked streaming with
// enable gaps, slip-induced relock, misalign counter clearing and async reset.

module tb_m_phy_lane_s2p;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       serial_in;
    logic       align_en;
    logic [9:0] parallel_out;
    logic       valid;
    logic       comma_det;
    logic       aligned;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    always #5 clk = ~clk;

    m_phy_lane_s2p dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .serial_in    (serial_in),
        .align_en     (align_en),
        .parallel_out (parallel_out),
        .valid        (valid),
        .comma_det    (comma_det),
        .aligned      (aligned)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic cycle(input logic en, input logic b);
        enable    = en;
        serial_in = b;
        @(posedge clk);
        #1;
        if (valid) n_valid++;
    endtask

    task automatic send_sym(input logic [9:0] sym, input bit gap);
        for (int i = 9; i >= 0; i--) begin
            cycle(1'b1, sym[i]);
            if (gap && i != 0) begin
                cycle(1'b0, ~sym[i]);
                check("idle_valid", 16'(valid), 16'h0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] filler;
        reset     = 1'b0;
        enable    = 1'b0;
        serial_in = 1'b0;
        align_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_parallel", 16'(parallel_out), 16'h000);
        check("rst_valid", 16'(valid), 16'h0);
        check("rst_comma", 16'(comma_det), 16'h0);
        check("rst_aligned", 16'(aligned), 16'h0);
        @(negedge clk);
        reset = 1'b1;

        // Random data and even a full comma with align_en=0: no acquisition.
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        send_sym(10'h0FA, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0);
        check("noalign_valid_cnt", 16'(n_valid), 16'h0);
        check("noalign_aligned", 16'(aligned), 16'h0);
        check("noalign_parallel", 16'(parallel_out), 16'h000);

        // Acquire on 0FA after three junk bits, then boundary comma 305.
        align_en = 1'b1;
        n_valid  = 0;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        send_sym(10'h0FA, 1'b0);
        check("acq_valid", 16'(valid), 16'h1);
        check("acq_comma", 16'(comma_det), 16'h1);
        check("acq_parallel", 16'(parallel_out), 16'h0FA);
        check("acq_aligned", 16'(aligned), 16'h1);
        check("acq_valid_cnt", 16'(n_valid), 16'h1);
        n_valid = 0;
        send_sym(10'h305, 1'b0);
        check("pos_valid", 16'(valid), 16'h1);
        check("pos_parallel", 16'(parallel_out), 16'h305);
        check("pos_comma", 16'(comma_det), 16'h1);
        check("pos_valid_cnt", 16'(n_valid), 16'h1);

        // Data symbols with enable toggling every other cycle.
        n_valid = 0;
        send_sym(10'h2AA, 1'b1);
        check("d0_valid", 16'(valid), 16'h1);
        check("d0_parallel", 16'(parallel_out), 16'h2AA);
        check("d0_comma", 16'(comma_det), 16'h0);
        cycle(1'b0, 1'b1);
        check("d0_hold_valid", 16'(valid), 16'h0);
        check("d0_hold_parallel", 16'(parallel_out), 16'h2AA);
        send_sym(10'h155, 1'b1);
        check("d1_valid", 16'(valid), 16'h1);
        check("d1_parallel", 16'(parallel_out), 16'h155);
        check("d1_comma", 16'(comma_det), 16'h0);
        check("data_valid_cnt", 16'(n_valid), 16'h2);

        // One-bit slip: two off-boundary commas drop lock.
        n_valid = 0;
        cycle(1'b1, 1'b0);
        send_sym(10'h0FA, 1'b0);
        check("slip1_valid", 16'(valid), 16'h0);
        check("slip1_aligned", 16'(aligned), 16'h1);
        check("slip1_parallel", 16'(parallel_out), 16'h07D);
        check("slip1_valid_cnt", 16'(n_valid), 16'h1);
        send_sym(10'h305, 1'b0);
        check("slip2_aligned", 16'(aligned), 16'h0);
        check("slip2_parallel", 16'(parallel_out), 16'h182);
        check("slip2_valid_cnt", 16'(n_valid), 16'h2);
        n_valid = 0;
        send_sym(10'h0FA, 1'b0);
        check("reacq_valid", 16'(valid), 16'h1);
        check("reacq_parallel", 16'(parallel_out), 16'h0FA);
        check("reacq_comma", 16'(comma_det), 16'h1);
        check("reacq_aligned", 16'(aligned), 16'h1);
        check("reacq_valid_cnt", 16'(n_valid), 16'h1);

        // Off-boundary, boundary, off-boundary: count cleared in between.
        cycle(1'b1, 1'b0);
        send_sym(10'h0FA, 1'b0);
        check("clr_off1_aligned", 16'(aligned), 16'h1);
        filler = 9'b010101010;
        for (int i = 8; i >= 0; i--) cycle(1'b1, filler[i]);
        send_sym(10'h0FA, 1'b0);
        check("clr_bnd_valid", 16'(valid), 16'h1);
        check("clr_bnd_comma", 16'(comma_det), 16'h1);
        check("clr_bnd_parallel", 16'(parallel_out), 16'h0FA);
        cycle(1'b1, 1'b0);
        send_sym(10'h0FA, 1'b0);
        check("clr_off2_valid", 16'(valid), 16'h0);
        check("clr_off2_aligned", 16'(aligned), 16'h1);

        // Async reset between edges with bit_cnt at 5.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i % 2 == 0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_parallel", 16'(parallel_out), 16'h000);
        check("arst_valid", 16'(valid), 16'h0);
        check("arst_comma", 16'(comma_det), 16'h0);
        check("arst_aligned", 16'(aligned), 16'h0);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'(i % 2 == 1));
        check("post_rst_valid_cnt", 16'(n_valid), 16'h0);
        check("post_rst_aligned", 16'(aligned), 16'h0);
        send_sym(10'h0FA, 1'b0);
        check("post_rst_acq_parallel", 16'(parallel_out), 16'h0FA);
        check("post_rst_acq_aligned", 16'(aligned), 16'h1);
        check("post_rst_acq_cnt", 16'(n_valid), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
